// File: rtl/acc_req_issuer_pkg.sv
// Shared accumulator-request definitions: channel count, timestamp width,
// and the per-entry record queued toward the parent FPR accumulators.
package acc_req_issuer_pkg;

  localparam int unsigned N_ACC    = 3;
  localparam int unsigned GC_WIDTH = 8;
  localparam int unsigned DEPTH    = 4;

  typedef struct packed {
    logic [31:0]         data;
    logic [GC_WIDTH-1:0] stamp;
  } acc_req_t;

  // Index width that stays legal for a single channel.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_req_issuer_if.sv
// Commit-side and parent-side accumulator-request signals of one core.
// master: the issuer; slave: the core commit stage plus the parent arbiter.
interface acc_req_issuer_if
  import acc_req_issuer_pkg::*;
#(
  parameter int unsigned N_ACC    = acc_req_issuer_pkg::N_ACC,
  parameter int unsigned GC_WIDTH = acc_req_issuer_pkg::GC_WIDTH
);
  localparam int unsigned IDX_W = idx_width(N_ACC);

  logic                               commit_acc;
  logic [IDX_W-1:0]                   commit_acc_idx;
  logic [31:0]                        commit_data;
  logic                               commit_ready;
  logic [N_ACC-1:0]                   acc_req_valid;
  logic [N_ACC-1:0]                   acc_req_ready;
  logic [N_ACC-1:0][31:0]             acc_data;
  logic [N_ACC-1:0][GC_WIDTH-1:0]     gc_stamp;

  modport master (
    input  commit_acc, commit_acc_idx, commit_data, acc_req_ready,
    output commit_ready, acc_req_valid, acc_data, gc_stamp
  );

  modport slave (
    output commit_acc, commit_acc_idx, commit_data, acc_req_ready,
    input  commit_ready, acc_req_valid, acc_data, gc_stamp
  );

endinterface

// File: rtl/acc_req_fifo.sv
// One accumulator channel: DEPTH-entry circular FIFO, registered head,
// no enqueue-to-output bypass, valid independent of deq_ready.
module acc_req_fifo
  import acc_req_issuer_pkg::*;
#(
  parameter int unsigned DEPTH   = acc_req_issuer_pkg::DEPTH,
  parameter type         entry_t = acc_req_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enq,
  input  entry_t enq_entry,
  input  logic   deq_ready,
  output logic   full,
  output logic   valid,
  output entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          do_enq;
  logic          do_deq;

  assign valid  = (count != '0);
  assign full   = (count == (PW+1)'(DEPTH));
  assign do_enq = enq && !full;
  assign do_deq = valid && deq_ready;
  assign head   = mem[rd_ptr];

  // Entry storage; contents are meaningless once pointers are reset.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  // Pointers wrap naturally at power-of-two DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_req_issuer.sv
// Per-core accumulator-request source: decodes committed accumulate ops
// into per-channel FIFOs stamped with the global counter.
module acc_req_issuer
  import acc_req_issuer_pkg::*;
#(
  parameter int unsigned N_ACC    = acc_req_issuer_pkg::N_ACC,
  parameter int unsigned GC_WIDTH = acc_req_issuer_pkg::GC_WIDTH,
  parameter int unsigned DEPTH    = acc_req_issuer_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [GC_WIDTH-1:0] gc,
  acc_req_issuer_if.master    bus,
  output logic                idle,
  output logic                bad_idx
);

  localparam int unsigned IDX_W = idx_width(N_ACC);

  typedef struct packed {
    logic [31:0]         data;
    logic [GC_WIDTH-1:0] stamp;
  } entry_t;

  logic             idx_ok;
  logic [N_ACC-1:0] enq;
  logic [N_ACC-1:0] full;
  logic [N_ACC-1:0] valid;
  entry_t           new_entry;
  entry_t           head [N_ACC];

  assign idx_ok    = int'(bus.commit_acc_idx) < int'(N_ACC);
  assign new_entry = '{data: bus.commit_data, stamp: gc};

  // Stall only when the addressed channel exists and is full.
  always_comb begin
    bus.commit_ready = 1'b1;
    for (int unsigned i = 0; i < N_ACC; i++) begin
      if (bus.commit_acc_idx == IDX_W'(i) && full[i]) bus.commit_ready = 1'b0;
    end
  end

  for (genvar g = 0; g < N_ACC; g++) begin : g_chan
    assign enq[g] = bus.commit_acc && (bus.commit_acc_idx == IDX_W'(g)) && !full[g];

    acc_req_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .enq       (enq[g]),
      .enq_entry (new_entry),
      .deq_ready (bus.acc_req_ready[g]),
      .full      (full[g]),
      .valid     (valid[g]),
      .head      (head[g])
    );

    assign bus.acc_data[g] = head[g].data;
    assign bus.gc_stamp[g] = head[g].stamp;
  end

  assign bus.acc_req_valid = valid;
  assign idle = !(|valid) && !(bus.commit_acc && idx_ok);

  // Sticky flag for accumulate ops addressed past the last channel.
  always_ff @(posedge clk) begin
    if (reset)                         bad_idx <= 1'b0;
    else if (bus.commit_acc && !idx_ok) bad_idx <= 1'b1;
  end

endmodule
